jtframe_joyser: RTL and testbench
=================================

JTFRAME_JOYSER -- requirements
Module: jtframe_joyser

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of daisy-chained controllers, range 1..4.
REQ-002 SHALL have parameter BITS, default 12: bits per controller, range 8..16.
REQ-003 SHALL have parameter DIV, default 16: clk_sys cycles per tick, minimum 2.
REQ-004 SHALL have parameter GAP, default 8: idle ticks between frames, minimum 1.
REQ-005 SHALL have parameter ACTIVE_LOW, default 1: when 1, each sampled JOY_DATA bit is inverted before storage.
REQ-006 SHALL have parameter COMBO_MASK, BITS wide, default 12'hC00: channel-0 bits that form the OSD combo.
REQ-007 SHALL have port clk_sys, input, 1 bit: the only clock.
REQ-008 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-009 SHALL have port en, input, 1 bit: scan enable, sampled only in IDLE.
REQ-010 SHALL have port JOY_CLK, output, 1 bit: serial shift clock to the adapter.
REQ-011 SHALL have port JOY_LOAD, output, 1 bit: parallel load strobe, active low.
REQ-012 SHALL have port JOY_DATA, input, 1 bit: serial data from the adapter.
REQ-013 SHALL have port joy_flat, output, CHANNELS*BITS bits: channel c occupies [c*BITS +: BITS], 1 = pressed.
REQ-014 SHALL have port joy_valid, output, 1 bit: one-cycle pulse when joy_flat updates.
REQ-015 SHALL have port osd_combo, output, 1 bit: high while every COMBO_MASK bit of channel 0 is pressed.

Function
REQ-016 SHALL generate a tick on the cycle a 0..DIV-1 counter equals DIV-1; the counter runs freely outside reset.
REQ-017 SHALL implement FSM states IDLE, LOAD, SHIFT and COMMIT, all transitions taken on tick unless stated otherwise.
REQ-018 SHALL, in IDLE, count GAP ticks, then enter LOAD only if en=1; if en=0 it SHALL stay in IDLE with the gap count saturated.
REQ-019 SHALL, in LOAD, drive JOY_LOAD=0 for exactly one tick period, then enter SHIFT with bit count 0.
REQ-020 SHALL, in SHIFT phase 0 on tick, sample JOY_DATA (after ACTIVE_LOW inversion) into shift position k = bit count, and drive JOY_CLK=1.
REQ-021 SHALL, in SHIFT phase 1 on tick, drive JOY_CLK=0 and increment the bit count; after bit CHANNELS*BITS-1 it SHALL enter COMMIT.
REQ-022 SHALL map the k-th sampled bit (k=0 first) to joy_flat[k].
REQ-023 SHALL, in COMMIT, update joy_flat, pulse joy_valid for one clk_sys cycle, and return to IDLE on the next clk_sys cycle without waiting for a tick.
REQ-024 SHALL register osd_combo from joy_flat, so it updates one cycle after joy_flat.
REQ-025 SHALL hold JOY_LOAD=1 and JOY_CLK=0 in IDLE and COMMIT.
REQ-026 SHALL give a frame length of 1 + 2*CHANNELS*BITS + GAP ticks plus one cycle.
REQ-027 SHALL NOT alter a frame already in progress when en falls.

Reset
REQ-028 SHALL, on any clk_sys edge with rst_n=0, set: FSM=IDLE, tick counter=0, gap count=0, bit count=0, shift register=0, joy_flat=0, joy_valid=0, osd_combo=0, JOY_LOAD=1, JOY_CLK=0.
REQ-029 SHALL discard any partial frame on a reset mid-SHIFT, leaving joy_flat=0 and producing no joy_valid pulse.

Configuration
REQ-030 SHALL, when macro JTFRAME_JOYSER_FILTER_EN is defined, update joy_flat and pulse joy_valid only when the new frame equals the previous raw frame; otherwise it SHALL keep the old value with no pulse.
REQ-031 SHALL, when JTFRAME_JOYSER_FILTER_EN is not defined, update joy_flat and pulse joy_valid on every COMMIT.
REQ-032 SHALL clear the previous-raw-frame register on reset.

Verification
REQ-033 Test: DIV=4, GAP=8, CHANNELS=2, BITS=12, en=1, reset released -> first JOY_LOAD low at cycle 32 lasting 4 cycles; 24 JOY_CLK pulses each 4 cycles high; joy_valid at cycle 229.
REQ-034 Test: ACTIVE_LOW=1, adapter pattern with only bits k=0 and k=13 low -> joy_flat=24'h002001.
REQ-035 Test: channel-0 bits 10 and 11 pressed -> osd_combo=1 one cycle after joy_valid; release either bit -> osd_combo=0 after the next frame.
REQ-036 Test: rst_n=0 for one cycle at bit 7 of SHIFT -> JOY_CLK=0, JOY_LOAD=1 next cycle; no joy_valid; the next frame starts after a full GAP.
REQ-037 Test: en=0 during SHIFT -> the current frame completes with joy_valid; no further JOY_LOAD until en=1.
REQ-038 Test: with FILTER_EN defined, frames A, B, B -> no update at B, then an update with joy_valid at the second B; with the macro undefined -> updates at A, B and B.

Source files
------------

// File: rtl/jtframe_joyser.sv
// Serial joystick adapter scanner: loads, shifts and publishes CHANNELS*BITS button bits.
// Optional macro JTFRAME_JOYSER_FILTER_EN: publish a frame only when it repeats the previous raw frame.
module jtframe_joyser #(
    parameter int CHANNELS   = 2,
    parameter int BITS       = 12,
    parameter int DIV        = 16,
    parameter int GAP        = 8,
    parameter int ACTIVE_LOW = 1,
    parameter logic [BITS-1:0] COMBO_MASK = BITS'(12'hC00)
) (
    input  logic                     clk_sys,
    input  logic                     rst_n,
    input  logic                     en,
    output logic                     JOY_CLK,
    output logic                     JOY_LOAD,
    input  logic                     JOY_DATA,
    output logic [CHANNELS*BITS-1:0] joy_flat,
    output logic                     joy_valid,
    output logic                     osd_combo
);

    localparam int N  = CHANNELS * BITS;
    localparam int TW = $clog2(DIV);
    localparam int GW = $clog2(GAP + 1);
    localparam int BW = $clog2(N);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q;
    logic [GW-1:0]   gap_q, gap_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic            phase_q, phase_d;
    logic            load_q, load_d;
    logic            jclk_q, jclk_d;
    logic [N-1:0]    shift_q;
    logic [N-1:0]    flat_q;
    logic            valid_q;
    logic            osd_q;
    logic            tick;
    logic            sample_en;
    logic            commit;
    logic            accept;
    logic            sample;

    assign tick   = (tick_q == TW'(DIV - 1));
    assign sample = (ACTIVE_LOW != 0) ? ~JOY_DATA : JOY_DATA;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) tick_q <= '0;
        else        tick_q <= tick ? '0 : tick_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        bit_d     = bit_q;
        phase_d   = phase_q;
        jclk_d    = 1'b0;
        sample_en = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    if (gap_q >= GW'(GAP - 1)) begin
                        // Gap elapsed: hold the count saturated until en allows a scan
                        if (en) begin
                            state_d = LOAD;
                            gap_d   = '0;
                        end else begin
                            gap_d   = GW'(GAP);
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            LOAD: begin
                if (tick) begin
                    state_d = SHIFT;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end
            end
            SHIFT: begin
                jclk_d = jclk_q;
                if (tick) begin
                    if (!phase_q) begin
                        sample_en = 1'b1;
                        jclk_d    = 1'b1;
                        phase_d   = 1'b1;
                    end else begin
                        jclk_d  = 1'b0;
                        phase_d = 1'b0;
                        if (bit_q == BW'(N - 1)) begin
                            state_d = COMMIT;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        load_d = (state_d != LOAD);
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gap_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            load_q  <= 1'b1;
            jclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            load_q  <= load_d;
            jclk_q  <= jclk_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_shift
            always_ff @(posedge clk_sys) begin
                if (!rst_n)                                   shift_q[gi] <= 1'b0;
                else if (sample_en && (bit_q == BW'(gi)))     shift_q[gi] <= sample;
            end
        end
    endgenerate

`ifdef JTFRAME_JOYSER_FILTER_EN
    logic [N-1:0] prev_q;

    assign accept = (shift_q == prev_q);

    always_ff @(posedge clk_sys) begin
        if (!rst_n)      prev_q <= '0;
        else if (commit) prev_q <= shift_q;
    end
`else
    assign accept = 1'b1;
`endif

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            flat_q  <= '0;
            valid_q <= 1'b0;
            osd_q   <= 1'b0;
        end else begin
            valid_q <= commit && accept;
            if (commit && accept) flat_q <= shift_q;
            osd_q   <= ((flat_q[BITS-1:0] & COMBO_MASK) == COMBO_MASK);
        end
    end

    assign JOY_CLK   = jclk_q;
    assign JOY_LOAD  = load_q;
    assign joy_flat  = flat_q;
    assign joy_valid = valid_q;
    assign osd_combo = osd_q;

endmodule

// File: tb/tb_jtframe_joyser.sv
// Directed bench for jtframe_joyser with a behavioural serial adapter model.
module tb_jtframe_joyser;

    localparam int CH  = 2;
    localparam int BT  = 12;
    localparam int N   = CH * BT;
    localparam int DIV = 4;
    localparam int GAP = 8;

    logic          clk_sys = 1'b0;
    logic          rst_n   = 1'b0;
    logic          en      = 1'b0;
    logic          jclk;
    logic          jload;
    logic          joy_data;
    logic [N-1:0]  joy_flat;
    logic          joy_valid;
    logic          osd_combo;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    jtframe_joyser #(
        .CHANNELS  (CH),
        .BITS      (BT),
        .DIV       (DIV),
        .GAP       (GAP),
        .ACTIVE_LOW(1)
    ) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .en       (en),
        .JOY_CLK  (jclk),
        .JOY_LOAD (jload),
        .JOY_DATA (joy_data),
        .joy_flat (joy_flat),
        .joy_valid(joy_valid),
        .osd_combo(osd_combo)
    );

    // Adapter: pressed buttons drive the line low; bit index restarts on load, advances on JOY_CLK fall
    logic [N-1:0] pressed = '0;
    int           adp_k   = 0;
    logic         jclk_prev = 1'b0;

    always @(negedge clk_sys) begin
        if (!jload)                 adp_k <= 0;
        else if (jclk_prev && !jclk) adp_k <= adp_k + 1;
        jclk_prev <= jclk;
    end

    assign joy_data = (adp_k < N) ? ~pressed[adp_k] : 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Observes 240 cycles after reset release (release happens at cycle 0)
    task automatic measure(output int first_load, output int load_len, output int pulses,
                           output int hi_min, output int hi_max, output int valid_cyc,
                           output int valid_cnt, output logic [N-1:0] flat_cap);
        int hi_run;
        first_load = -1; load_len = 0; pulses = 0; hi_min = 999; hi_max = 0;
        valid_cyc = -1; valid_cnt = 0; flat_cap = '0; hi_run = 0;
        for (int c = 1; c <= 240; c++) begin
            @(negedge clk_sys);
            if (!jload) begin
                if (first_load < 0) first_load = c;
                load_len++;
            end
            if (jclk) hi_run++;
            else if (hi_run > 0) begin
                pulses++;
                if (hi_run < hi_min) hi_min = hi_run;
                if (hi_run > hi_max) hi_max = hi_run;
                hi_run = 0;
            end
            if (joy_valid) begin
                valid_cnt++;
                if (valid_cyc < 0) begin
                    valid_cyc = c;
                    flat_cap  = joy_flat;
                end
            end
        end
    endtask

    task automatic wait_load(output int cycles);
        cycles = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk_sys);
            if (!jload) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic wait_valid(output logic got);
        got = 1'b0;
        for (int c = 1; c <= 210; c++) begin
            @(negedge clk_sys);
            if (joy_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic frame(input string tag, output logic got);
        int cyc;
        wait_load(cyc);
        if (cyc < 0) check({tag, "_load_seen"}, 32'd0, 32'd1);
        wait_valid(got);
    endtask

    initial begin
        int fl, ll, pu, hmin, hmax, vc, vn, cyc, cnt, loads;
        logic [N-1:0] fc;
        logic got;

        en      = 1'b1;
        pressed = 24'h002001;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("rst_load",  32'(jload),     32'd1);
        check("rst_clk",   32'(jclk),      32'd0);
        check("rst_flat",  32'(joy_flat),  32'd0);
        check("rst_valid", 32'(joy_valid), 32'd0);
        check("rst_osd",   32'(osd_combo), 32'd0);

        rst_n = 1'b1;
        measure(fl, ll, pu, hmin, hmax, vc, vn, fc);
        check("t1_first_load", fl,   32'd32);
        check("t1_load_len",   ll,   32'd4);
        check("t1_clk_pulses", pu,   32'd24);
        check("t1_clk_hi_min", hmin, 32'd4);
        check("t1_clk_hi_max", hmax, 32'd4);
        check("t1_valid_cyc",  vc,   32'd229);
        check("t1_valid_cnt",  vn,   32'd1);
        check("t1_flat",       32'(fc), 32'h002001);
        check("t1_osd",        32'(osd_combo), 32'd0);

        pressed = 24'h000C00;
        frame("combo", got);
        check("combo_valid", 32'(got),       32'd1);
        check("combo_flat",  32'(joy_flat),  32'h000C00);
        check("combo_osd_0", 32'(osd_combo), 32'd0);
        @(negedge clk_sys);
        check("combo_osd_1", 32'(osd_combo), 32'd1);
        check("combo_pulse", 32'(joy_valid), 32'd0);

        pressed = 24'h000400;
        frame("release", got);
        check("release_flat", 32'(joy_flat), 32'h000400);
        @(negedge clk_sys);
        check("release_osd",  32'(osd_combo), 32'd0);

        pressed = 24'hA5C3F0;
        frame("pattern", got);
        check("pattern_valid", 32'(got),      32'd1);
        check("pattern_flat",  32'(joy_flat), 32'hA5C3F0);

        // Reset while bit 7 is being clocked out
        pressed = 24'hFFFFFF;
        wait_load(cyc);
        check("mid_load_seen", 32'(cyc >= 0), 32'd1);
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_sys);
            if (jclk && !jclk_prev) cnt++;
            if (cnt == 8) break;
        end
        rst_n = 1'b0;
        @(negedge clk_sys);
        check("mid_rst_clk",   32'(jclk),      32'd0);
        check("mid_rst_load",  32'(jload),     32'd1);
        check("mid_rst_flat",  32'(joy_flat),  32'd0);
        check("mid_rst_valid", 32'(joy_valid), 32'd0);
        rst_n = 1'b1;
        measure(fl, ll, pu, hmin, hmax, vc, vn, fc);
        check("mid_first_load", fl, 32'd32);
        check("mid_valid_cyc",  vc, 32'd229);
        check("mid_flat",       32'(fc), 32'hFFFFFF);

        // Dropping en mid-frame lets the frame finish, then scanning stops
        pressed = 24'h00000F;
        wait_load(cyc);
        repeat (20) @(negedge clk_sys);
        en = 1'b0;
        wait_valid(got);
        check("en_off_valid", 32'(got),      32'd1);
        check("en_off_flat",  32'(joy_flat), 32'h00000F);
        loads = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk_sys);
            if (!jload) loads++;
        end
        check("en_off_no_load", loads, 32'd0);
        en = 1'b1;
        wait_load(cyc);
        check("en_on_load_soon", 32'(cyc >= 1 && cyc <= DIV), 32'd1);
        wait_valid(got);
        check("en_on_valid", 32'(got), 32'd1);

        // Frames A, B, B
        pressed = 24'h0000F1;
        frame("A", got);
`ifdef JTFRAME_JOYSER_FILTER_EN
        check("A_valid", 32'(got), 32'd0);
`else
        check("A_valid", 32'(got),      32'd1);
        check("A_flat",  32'(joy_flat), 32'h0000F1);
`endif
        pressed = 24'h123456;
        frame("B1", got);
`ifdef JTFRAME_JOYSER_FILTER_EN
        check("B1_valid", 32'(got), 32'd0);
`else
        check("B1_valid", 32'(got),      32'd1);
        check("B1_flat",  32'(joy_flat), 32'h123456);
`endif
        frame("B2", got);
        check("B2_valid", 32'(got),      32'd1);
        check("B2_flat",  32'(joy_flat), 32'h123456);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
